// File: rtl/mod_fifo_pkg.sv
// Shared definitions for the memory-mapped FIFO peripheral: register map,
// bit positions inside STATUS/CTRL, bus request bits and response FSM states.
package mod_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UNF   = 3;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  localparam int DRW_WR = 0;
  localparam int DRW_RD = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/mod_fifo_core.sv
// Circular buffer of 32-bit words: head/tail pointers, storage and an
// occupancy count one bit wider than the pointers so full and empty differ.
module fifo_core #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[head_q];

  always_comb begin
    do_push = push & ~full & ~flush;
    do_pop  = pop & ~empty & ~flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) tail_d = tail_q + AW'(1);
      if (do_pop)  head_d = head_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata;
  end

endmodule

// File: rtl/mod_fifo.sv
// Bus responder wrapping fifo_core: address decode, sticky flags and a
// registered one-wait-state read response.
//   state  | meaning
//   S_IDLE | accept requests; reads stall while dout is loaded
//   S_RESP | dout valid, held request ignored, back to S_IDLE
module mod_fifo
  import mod_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic [1:0]  drw,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall
);

  state_e      state_q, state_d;
  logic [31:0] dout_q, dout_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        push, pop, flush;
  logic [31:0] rdata;
  logic [AW:0] count;
  logic        full, empty;
  logic        wr_req, rd_req;
  logic [1:0]  reg_sel;
  logic        unused_addr;

  assign reg_sel     = daddr[3:2];
  assign wr_req      = de & drw[DRW_WR];
  assign rd_req      = de & drw[DRW_RD] & ~drw[DRW_WR];
  assign unused_addr = ^{daddr[31:4], daddr[1:0]};
  assign dout        = dout_q;

  fifo_core #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (din),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          case (reg_sel)
            REG_DATA: begin
              push = 1'b1;
              if (full) ovf_d = 1'b1;
            end
            REG_CTRL: begin
              flush = din[CTRL_FLUSH];
              if (din[CTRL_CLR]) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
              end
            end
            default: ;
          endcase
        end else if (rd_req) begin
          // Gated by rst so a held request cannot keep stall up through reset.
          stall   = ~rst;
          state_d = S_RESP;
          dout_d  = '0;
          case (reg_sel)
            REG_DATA: begin
              if (empty) begin
                unf_d = 1'b1;
              end else begin
                dout_d = rdata;
                pop    = 1'b1;
              end
            end
            REG_STATUS: begin
              dout_d[ST_EMPTY] = empty;
              dout_d[ST_FULL]  = full;
              dout_d[ST_OVF]   = ovf_q;
              dout_d[ST_UNF]   = unf_q;
            end
            REG_COUNT: dout_d = 32'(count);
            default:   dout_d = '0;
          endcase
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_mod_fifo.sv
// Scenario bench for mod_fifo: a queue model of the FIFO plus sticky flags
// predicts every DATA/STATUS/COUNT read.
module tb_mod_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        de;
  logic [1:0]  drw;
  logic [31:0] daddr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb [$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  mod_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .de    (de),
    .drw   (drw),
    .daddr (daddr),
    .din   (din),
    .dout  (dout),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s    = '0;
    s[0] = (sb.size() == 0);
    s[1] = (sb.size() == DEPTH);
    s[2] = m_ovf;
    s[3] = m_unf;
    return s;
  endfunction

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] d, input logic [1:0] rw);
    de    = 1'b1;
    drw   = rw;
    daddr = {28'h0, sel, 2'b00};
    din   = d;
    @(posedge clk); #1;
    de    = 1'b0;
    drw   = 2'b00;
  endtask

  // Read with the request held through the response cycle, as the CPU does.
  task automatic bus_read(input logic [1:0] sel, output logic [31:0] data, output int stalls);
    data   = 'x;
    stalls = 0;
    de     = 1'b1;
    drw    = 2'b10;
    daddr  = {28'h0, sel, 2'b00};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
      end else begin
        data = dout;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    de  = 1'b0;
    drw = 2'b00;
  endtask

  task automatic push_data(input logic [31:0] d, input logic [1:0] rw);
    bus_write(2'd0, d, rw);
    if (sb.size() < DEPTH) sb.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    bus_write(2'd3, d, 2'b01);
    if (d[0]) sb.delete();
    if (d[1]) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
  endtask

  task automatic model_pop(output logic [31:0] exp);
    if (sb.size() > 0) exp = sb.pop_front();
    else begin
      exp   = '0;
      m_unf = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int          s;
    rst = 1'b1; de = 1'b0; drw = 2'b00; daddr = '0; din = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b dout=%h, expected 0 and 00000000", stall, dout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== 32'h1 || s !== 1) begin
      n_fail++;
      $display("FAIL reset_status: dout=%h stalls=%0d, expected 00000001 stalls=1", d, s);
    end
    bus_read(2'd2, d, s);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_count: got %h expected 00000000", d);
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] d, e;
    int          s;
    for (int i = 1; i <= 3; i++) begin
      de = 1'b1; drw = 2'b01; daddr = 32'h0; din = 32'hA5A5_0000 + i;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++;
        $display("FAIL write_stall: stall=%b expected 0", stall);
      end
      @(posedge clk); #1;
      de = 1'b0; drw = 2'b00;
      sb.push_back(32'hA5A5_0000 + i);
    end
    bus_write(2'd1, 32'hF, 2'b01);
    bus_write(2'd2, 32'h5, 2'b01);
    bus_read(2'd2, d, s);
    n_checks++;
    if (d !== 32'(sb.size())) begin
      n_fail++;
      $display("FAIL count_after_push: got %h expected %h", d, 32'(sb.size()));
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd0, d, s);
      model_pop(e);
      n_checks++;
      if (d !== e || s !== 1) begin
        n_fail++;
        $display("FAIL pop_order[%0d]: got %h stalls=%0d expected %h stalls=1", i, d, s, e);
      end
    end
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== exp_status()) begin
      n_fail++;
      $display("FAIL status_after_pop: got %h expected %h", d, exp_status());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    int          s;
    for (int i = 0; i <= DEPTH; i++) push_data(32'h0900 + i, 2'b01);
    bus_read(2'd2, d, s);
    n_checks++;
    if (d !== 32'(DEPTH)) begin
      n_fail++;
      $display("FAIL count_full: got %h expected %h", d, 32'(DEPTH));
    end
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== 32'h6 || d !== exp_status()) begin
      n_fail++;
      $display("FAIL status_overflow: got %h expected 00000006", d);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(2'd0, d, s);
      model_pop(e);
      n_checks++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL overflow_pop[%0d]: got %h expected %h", i, d, e);
      end
    end
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== exp_status()) begin
      n_fail++;
      $display("FAIL status_ovf_sticky: got %h expected %h", d, exp_status());
    end
    ctrl_write(32'h2);
  endtask

  task automatic test_underflow();
    logic [31:0] d, e;
    int          s;
    bus_read(2'd0, d, s);
    model_pop(e);
    n_checks++;
    if (d !== e || s !== 1) begin
      n_fail++;
      $display("FAIL underflow_data: got %h stalls=%0d expected %h stalls=1", d, s, e);
    end
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== 32'h9 || d !== exp_status()) begin
      n_fail++;
      $display("FAIL status_underflow: got %h expected 00000009", d);
    end
    ctrl_write(32'h2);
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== exp_status()) begin
      n_fail++;
      $display("FAIL status_clear: got %h expected %h", d, exp_status());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    int          s;
    for (int i = 0; i < 6; i++) push_data(32'h0600 + i, (i % 2 == 0) ? 2'b11 : 2'b01);
    for (int i = 0; i < 6; i++) begin
      bus_read(2'd0, d, s);
      model_pop(e);
      n_checks++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL wrap_first[%0d]: got %h expected %h", i, d, e);
      end
    end
    for (int i = 0; i < DEPTH; i++) push_data(32'h0100 + i, 2'b01);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(2'd0, d, s);
      model_pop(e);
      n_checks++;
      if (d !== e || s !== 1) begin
        n_fail++;
        $display("FAIL wrap_pop[%0d]: got %h stalls=%0d expected %h stalls=1", i, d, s, e);
      end
    end
    bus_read(2'd2, d, s);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_count: got %h expected 00000000", d);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    int          s;
    for (int i = 0; i <= DEPTH; i++) push_data(32'h0F00 + i, 2'b01);
    ctrl_write(32'h1);
    bus_read(2'd2, d, s);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_count: got %h expected 00000000", d);
    end
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== 32'h5 || d !== exp_status()) begin
      n_fail++;
      $display("FAIL flush_keeps_sticky: got %h expected 00000005", d);
    end
    ctrl_write(32'h3);
    push_data(32'hCAFE_0001, 2'b01);
    bus_read(2'd0, d, s);
    model_pop(e);
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL flush_then_pop: got %h expected %h", d, e);
    end
    bus_read(2'd1, d, s);
    n_checks++;
    if (d !== exp_status()) begin
      n_fail++;
      $display("FAIL flush_clear_status: got %h expected %h", d, exp_status());
    end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] d, e;
    int          s;
    push_data(32'hBEEF_0001, 2'b01);
    push_data(32'hBEEF_0002, 2'b01);
    de = 1'b1; drw = 2'b10; daddr = 32'h0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_stall: stall=%b expected 1", stall);
    end
    @(posedge clk); #1;
    model_pop(e);
    n_checks++;
    if (stall !== 1'b0 || dout !== e) begin
      n_fail++;
      $display("FAIL resp_data: stall=%b dout=%h expected 0 and %h", stall, dout, e);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: stall=%b dout=%h expected 0 and 00000000", stall, dout);
    end
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_req_stall: stall=%b expected 0", stall);
    end
    de = 1'b0; drw = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
    bus_read(2'd2, d, s);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL count_after_reset: got %h expected 00000000", d);
    end
    push_data(32'hD00D_0001, 2'b01);
    push_data(32'hD00D_0002, 2'b01);
    bus_read(2'd0, d, s);
    model_pop(e);
    n_checks++;
    if (d !== e || s !== 1) begin
      n_fail++;
      $display("FAIL held_read_after_reset: got %h stalls=%0d expected %h stalls=1", d, s, e);
    end
    bus_read(2'd2, d, s);
    n_checks++;
    if (d !== 32'(sb.size())) begin
      n_fail++;
      $display("FAIL single_pop_count: got %h expected %h", d, 32'(sb.size()));
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_wrap();
    test_flush();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_fifo.md
Name: mod_fifo

Overview:
- Memory-mapped 32-bit FIFO peripheral; the responder end of the CPU/arbiter data bus.
- The arbiter decodes its address window and forwards `de`, `drw`, `daddr` and `din`. The block returns `dout` and `stall`.
- Software pushes words through a data register and pops them through the same register. Status, count and control registers sit alongside it.
- Read responses take a registered, one-wait-state handshake, so the head RAM can map to block RAM.

Parameters:
- DEPTH, 8: number of 32-bit entries; must be a power of two, from 2 to 256.
- AW, log2(DEPTH): pointer width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- de  input  1  data enable; the arbiter selected this peripheral this cycle.
- drw  input  2  bit0 = write request, bit1 = read request; both set counts as a write only.
- daddr  input  32  byte address; only daddr[3:2] is decoded.
- din  input  32  write data from the CPU.
- dout  output  32  read data, registered.
- stall  output  1  holds the CPU while a read response is pending.

Behaviour:
- Register map, selected by daddr[3:2]:
  - 0 DATA: write pushes din; read pops the head.
  - 1 STATUS: read returns {28'b0, underflow, overflow, full, empty}.
  - 2 COUNT: read returns zero-extended count, 0..DEPTH.
  - 3 CTRL: write bit0=1 flushes (pointers and count to 0); write bit1=1 clears both sticky flags; read returns 0.
- Writes to STATUS and COUNT are ignored.
- Reset (async, rst=1):
  - dout=0, stall=0, count=0, head=tail=0, overflow=0, underflow=0, FSM=IDLE.
  - Storage contents are don't-care.
- FSM states are IDLE and RESP.
- IDLE, no request (de=0 or drw=00): stall=0, no action.
- IDLE, write (de & drw[0]):
  - Completes in the same cycle; stall=0; FSM stays IDLE.
  - Push on the clock edge if not full; tail increments mod DEPTH, count+1.
  - Push while full: data dropped, overflow set (sticky), count unchanged.
- IDLE, read (de & drw[1] & ~drw[0]):
  - stall=1 combinationally in the request cycle; at the edge dout is loaded, FSM goes to RESP.
  - DATA read, not empty: dout=mem[head]; head increments mod DEPTH; count-1.
  - DATA read while empty: dout=0, underflow set (sticky), pointers unchanged.
- RESP:
  - stall=0; dout holds the value; the CPU samples it this cycle.
  - The still-present request is ignored: no second pop and no second write.
  - Next state IDLE unconditionally.
  - Read latency is therefore 2 cycles: request cycle with stall, then data cycle.
- Back-to-back: a new request in the cycle after RESP is serviced normally.
- Status flags:
  - full = (count==DEPTH); empty = (count==0).
  - Count width is AW+1, so the full and empty conditions are unambiguous.
  - Pointers wrap silently at DEPTH-1 -> 0.
- Flush and flag-clear act at the edge of the CTRL write. A flush does not clear the sticky flags unless bit1 is also set.
- de=0 in any state: no side effects. RESP still returns to IDLE.
- An asserted rst clears everything immediately, including a pending RESP; stall drops asynchronously.

Decomposition:
- Shared package or header holds:
  - register offsets REG_DATA=0, REG_STATUS=1, REG_COUNT=2, REG_CTRL=3;
  - STATUS bit indices;
  - CTRL bit indices;
  - drw bit meanings DRW_WR=0, DRW_RD=1;
  - FSM state encodings.
- Sub-module fifo_core(clk, rst, push, pop, flush, wdata, rdata, count, full, empty): pointers, storage and count, parameterised by DEPTH.
- mod_fifo wraps fifo_core with the address decode, the response FSM and the sticky flags.

Test Plan:
- Reset then read STATUS -> stall high 1 cycle, then dout=0x00000001 (empty); COUNT reads 0.
- Write DATA 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 then read COUNT -> 3. Three DATA reads return 0x...0001, 0x...0002, 0x...0003 in order, each with exactly one stall cycle. STATUS is then 0x1.
- Push DEPTH+1 words (9 for DEPTH=8) -> COUNT=8; STATUS=0x6 (full, overflow). The ninth word never appears on pop.
- DATA read while empty -> dout=0; STATUS=0x9 (underflow, empty). Write CTRL=0x2 -> STATUS=0x1.
- Wrap-around: push 6, pop 6, push 8 distinct values (0x100..0x107), pop 8 -> values return in order; COUNT returns to 0.
- Assert rst during the RESP cycle of a DATA read -> stall=0 and dout=0 immediately; COUNT reads 0 afterward. A held request after reset release performs exactly one pop.
